arith_unit_scheduler: RTL and testbench
=======================================

// Module: arith_unit_scheduler
// PURPOSE
//  Shares one multiplier_booth (mul) and one divide unit (div) between NUM_REQ requesters
//  (interpolation FSM, solver cores). Round-robin arbitration, latches operands, pulses start,
//  waits for done, returns result to the owner.
//  Sits between the requester datapaths and the arithmetic units; one operation in flight at a time.
// PARAMETERS
//  NUM_REQ        2   number of requesters (2..8)
//  WORD_SIZE      16  operand/result width (fixed-point, same format as the units)
//  TIMEOUT_CYCLES 64  watchdog limit in WAIT (used only with ARITH_SCHED_TIMEOUT_EN)
// PORTS
//  clk         in   1                  clock, rising edge
//  rst         in   1                  synchronous, active-high reset
//  req         in   NUM_REQ            request level per requester, held until its resp_valid
//  req_op      in   NUM_REQ            per-requester op: 0 = mul, 1 = div
//  req_a       in   NUM_REQ*WORD_SIZE  operand A, requester i at [i*WORD_SIZE +: WORD_SIZE]
//  req_b       in   NUM_REQ*WORD_SIZE  operand B, same packing
//  gnt         out  NUM_REQ            one-hot owner, high from ISSUE through RESP
//  resp_valid  out  NUM_REQ            one-cycle pulse to owner, result valid
//  resp_data   out  WORD_SIZE          result, valid with resp_valid, held until next RESP
//  resp_ovf    out  1                  overflow flag of the unit used, valid with resp_valid
//  busy        out  1                  high in any state other than IDLE
//  timeout     out  1                  sticky watchdog flag; tied 0 without ARITH_SCHED_TIMEOUT_EN
//  unit_a      out  WORD_SIZE          latched operand A to both units
//  unit_b      out  WORD_SIZE          latched operand B to both units
//  mul_start   out  1                  one-cycle start pulse to multiplier
//  div_start   out  1                  one-cycle start pulse to divider
//  mul_result  in   WORD_SIZE          multiplier result
//  mul_done    in   1                  multiplier done
//  mul_ovf     in   1                  multiplier overflow
//  div_result  in   WORD_SIZE          divider result
//  div_done    in   1                  divider done
//  div_ovf     in   1                  divider overflow
// BEHAVIOUR
//  Reset: state = IDLE, rr_ptr = 0; all outputs 0 (gnt, resp_valid, resp_data, resp_ovf,
//   busy, timeout, unit_a, unit_b, mul_start, div_start). Reset mid-operation abandons it,
//   no response issued. Units are reset by the same rst.
//  FSM (registered state and outputs):
//   IDLE:  any req -> pick first set bit scanning rr_ptr, rr_ptr+1, .. (mod NUM_REQ);
//          latch owner index, op, unit_a, unit_b -> ISSUE.
//   ISSUE: gnt[owner]=1; exactly one of mul_start/div_start = 1 for this cycle -> WAIT.
//   WAIT:  only done of the selected unit counts; the other unit's done is ignored.
//          On done: latch result and ovf -> RESP.
//   RESP:  resp_valid[owner] = 1 for one cycle; rr_ptr = owner+1 (wrap at NUM_REQ) -> IDLE.
//  Latency: req seen in IDLE at cycle N -> start at N+1; unit done at cycle D -> resp_valid at D+1.
//  Minimum 1 idle cycle between operations; the last owner has lowest priority in the next pick.
//  req dropped after latch: the operation still completes, resp_valid still pulses (requester ignores it).
//  req_a/req_b/req_op changes after latch have no effect.
//  done already high in ISSUE is ignored; only sampled in WAIT.
// CONFIGURATION
//  ARITH_SCHED_TIMEOUT_EN defined: WAIT counter, cleared on entry; at TIMEOUT_CYCLES without done
//   -> RESP with resp_data = 0, resp_ovf = 1, timeout set (sticky until rst).
//  Not defined: no counter; WAIT lasts until done; timeout = 0.
// STRUCTURE
//  Package arith_sched_pkg: state encoding (IDLE, ISSUE, WAIT, RESP), OP_MUL/OP_DIV constants.
//  Sub-module rr_pick: combinational rotate-priority encoder (req, rr_ptr -> owner, any).
//  Top holds the FSM, operand/result registers and the optional watchdog.
// TESTING
//  1. NUM_REQ=2; req0 mul a=0x0180 b=0x0100, unit done 6 cycles after start
//     -> gnt=01, mul_start 1 cycle, resp_valid=01 at done+1 with mul_result.
//  2. req0 and req1 high together from reset -> owner 0 first, then 1;
//     req0 re-requests while 1 is served -> order 0,1,0.
//  3. req1 div, divider asserts div_ovf with done -> resp_ovf=1 with resp_valid=10;
//     a spurious mul_done in WAIT causes no response.
//  4. rst asserted in WAIT -> next cycle all outputs 0, no resp_valid;
//     new req served starting from requester 0.
//  5. With ARITH_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=8, done never arrives
//     -> resp_valid 8 cycles into WAIT, resp_data=0, resp_ovf=1, timeout stays 1.
//  6. Operands changed one cycle after the latch -> unit_a/unit_b hold the latched values until the next ISSUE.

Source files
------------

// File: rtl/arith_sched_pkg.sv
// -----------------------------------------------------------------------------
// arith_sched_pkg
//   Shared definitions for the arithmetic-unit scheduler: FSM state encoding,
//   operation codes and a small one-hot helper used by the top level.
// -----------------------------------------------------------------------------
package arith_sched_pkg;

  // Scheduler FSM states; one operation is in flight from ISSUE through RESP.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Per-requester operation select carried on req_op.
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Maximum number of requesters the scheduler is dimensioned for.
  localparam int MAX_REQ = 8;

  // One-hot decode of a requester index into an 8-bit vector; callers
  // truncate to their own requester count.
  function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [2:0] idx);
    logic [MAX_REQ-1:0] v;
    v = 8'b0000_0000;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/arith_unit_scheduler_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational rotate-priority encoder. Scans the request vector starting at
//   i_rr_ptr and wrapping at NUM_REQ; the first set bit wins.
// Ports
//   i_req    [NUM_REQ]  request vector
//   i_rr_ptr [PTR_W]    index with highest priority this round
//   o_owner  [PTR_W]    index of the winning requester (0 when none)
//   o_any    [1]        at least one request is set
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_rr_ptr,
  output logic [PTR_W-1:0]   o_owner,
  output logic               o_any
);

  logic             w_found;
  logic [PTR_W-1:0] w_idx;
  int               w_sum;

  // Walk the requesters in rotated order and keep the first one found.
  always_comb begin
    w_found = 1'b0;
    o_owner = '0;
    w_idx   = '0;
    w_sum   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // i_rr_ptr is always < NUM_REQ, so one subtraction performs the wrap.
      w_sum = int'(i_rr_ptr) + k;
      if (w_sum >= NUM_REQ) begin
        w_sum = w_sum - NUM_REQ;
      end else begin
        w_sum = w_sum;
      end
      w_idx = PTR_W'(w_sum);
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        o_owner = w_idx;
      end else begin
        w_found = w_found;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/arith_unit_scheduler.sv
// -----------------------------------------------------------------------------
// arith_unit_scheduler
//   Shares one multiplier and one divider between NUM_REQ requesters. A
//   round-robin pick selects an owner, its operands and op are latched, a
//   one-cycle start pulse goes to the selected unit, the scheduler waits for
//   that unit's done and returns the result to the owner with a one-cycle
//   resp_valid pulse. One operation is in flight at a time.
//
// Optional feature: define ARITH_SCHED_TIMEOUT_EN to enable a WAIT watchdog.
//   After TIMEOUT_CYCLES cycles in WAIT without done the operation is closed
//   with resp_data = 0, resp_ovf = 1 and the sticky timeout flag is set.
//   Without the macro there is no counter and timeout is tied low.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   req/req_op [NUM_REQ]     request level and op (0 mul, 1 div) per requester
//   req_a/req_b              packed operands, requester i at [i*WORD_SIZE +: WORD_SIZE]
//   gnt [NUM_REQ]            one-hot owner from ISSUE through RESP
//   resp_valid [NUM_REQ]     one-cycle result pulse to the owner
//   resp_data, resp_ovf      result and overflow, held until the next RESP
//   busy                     high whenever the FSM is not IDLE
//   timeout                  sticky watchdog flag
//   unit_a/unit_b            latched operands to both units
//   mul_start/div_start      one-cycle start pulses
//   mul_*/div_*              unit result, done and overflow inputs
// -----------------------------------------------------------------------------
module arith_unit_scheduler
  import arith_sched_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int WORD_SIZE      = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_op,
  input  logic [NUM_REQ*WORD_SIZE-1:0]   req_a,
  input  logic [NUM_REQ*WORD_SIZE-1:0]   req_b,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [WORD_SIZE-1:0]           resp_data,
  output logic                           resp_ovf,
  output logic                           busy,
  output logic                           timeout,
  output logic [WORD_SIZE-1:0]           unit_a,
  output logic [WORD_SIZE-1:0]           unit_b,
  output logic                           mul_start,
  output logic                           div_start,
  input  logic [WORD_SIZE-1:0]           mul_result,
  input  logic                           mul_done,
  input  logic                           mul_ovf,
  input  logic [WORD_SIZE-1:0]           div_result,
  input  logic                           div_done,
  input  logic                           div_ovf
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Reject configurations the scheduler is not dimensioned for.
  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("arith_unit_scheduler: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  // Registered state and outputs
  state_t                 r_state;
  logic [PTR_W-1:0]       r_rr_ptr;
  logic [PTR_W-1:0]       r_owner;
  logic                   r_op;
  logic [WORD_SIZE-1:0]   r_unit_a;
  logic [WORD_SIZE-1:0]   r_unit_b;
  logic [NUM_REQ-1:0]     r_gnt;
  logic [NUM_REQ-1:0]     r_resp_valid;
  logic [WORD_SIZE-1:0]   r_resp_data;
  logic                   r_resp_ovf;
  logic                   r_busy;
  logic                   r_mul_start;
  logic                   r_div_start;

  // Next-state values
  state_t                 w_state_nxt;
  logic [PTR_W-1:0]       w_rr_ptr_nxt;
  logic [PTR_W-1:0]       w_owner_nxt;
  logic                   w_op_nxt;
  logic [WORD_SIZE-1:0]   w_unit_a_nxt;
  logic [WORD_SIZE-1:0]   w_unit_b_nxt;
  logic [NUM_REQ-1:0]     w_gnt_nxt;
  logic [NUM_REQ-1:0]     w_resp_valid_nxt;
  logic [WORD_SIZE-1:0]   w_resp_data_nxt;
  logic                   w_resp_ovf_nxt;
  logic                   w_busy_nxt;
  logic                   w_mul_start_nxt;
  logic                   w_div_start_nxt;

  // Arbiter and selected-unit views
  logic [PTR_W-1:0]       w_pick_owner;
  logic                   w_pick_any;
  logic [NUM_REQ-1:0]     w_pick_onehot;
  logic [MAX_REQ-1:0]     w_pick_onehot_full;
  logic [PTR_W-1:0]       w_owner_inc;
  logic                   w_sel_done;
  logic [WORD_SIZE-1:0]   w_sel_result;
  logic                   w_sel_ovf;

`ifdef ARITH_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0]        r_wd_cnt;
  logic [WD_W-1:0]        w_wd_cnt_nxt;
  logic                   r_timeout;
  logic                   w_timeout_nxt;
  logic                   w_wd_expire;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .i_req    (req),
    .i_rr_ptr (r_rr_ptr),
    .o_owner  (w_pick_owner),
    .o_any    (w_pick_any)
  );

  // Decode winner to one-hot, compute owner+1 with wrap, and route the
  // selected unit's done/result/ovf according to the latched op.
  always_comb begin
    w_pick_onehot_full = idx_to_onehot(3'(w_pick_owner));
    w_pick_onehot      = w_pick_onehot_full[NUM_REQ-1:0];
    if (r_owner == PTR_W'(NUM_REQ - 1)) begin
      w_owner_inc = '0;
    end else begin
      w_owner_inc = r_owner + PTR_W'(1);
    end
    if (r_op == OP_DIV) begin
      w_sel_done   = div_done;
      w_sel_result = div_result;
      w_sel_ovf    = div_ovf;
    end else begin
      w_sel_done   = mul_done;
      w_sel_result = mul_result;
      w_sel_ovf    = mul_ovf;
    end
  end

`ifdef ARITH_SCHED_TIMEOUT_EN
  // Watchdog fires on the last allowed WAIT cycle when done is still absent.
  always_comb begin
    w_wd_expire = (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  end
`endif

  // FSM next-state and next-output computation.
  always_comb begin
    w_state_nxt      = r_state;
    w_rr_ptr_nxt     = r_rr_ptr;
    w_owner_nxt      = r_owner;
    w_op_nxt         = r_op;
    w_unit_a_nxt     = r_unit_a;
    w_unit_b_nxt     = r_unit_b;
    w_gnt_nxt        = r_gnt;
    w_resp_valid_nxt = '0;
    w_resp_data_nxt  = r_resp_data;
    w_resp_ovf_nxt   = r_resp_ovf;
    w_busy_nxt       = r_busy;
    w_mul_start_nxt  = 1'b0;
    w_div_start_nxt  = 1'b0;
`ifdef ARITH_SCHED_TIMEOUT_EN
    w_wd_cnt_nxt     = r_wd_cnt;
    w_timeout_nxt    = r_timeout;
`endif

    case (r_state)
      S_IDLE: begin
        if (w_pick_any) begin
          // Latch everything now so later changes on the request side are ignored.
          w_state_nxt     = S_ISSUE;
          w_owner_nxt     = w_pick_owner;
          w_op_nxt        = req_op[w_pick_owner];
          w_unit_a_nxt    = req_a[int'(w_pick_owner)*WORD_SIZE +: WORD_SIZE];
          w_unit_b_nxt    = req_b[int'(w_pick_owner)*WORD_SIZE +: WORD_SIZE];
          w_gnt_nxt       = w_pick_onehot;
          w_busy_nxt      = 1'b1;
          w_mul_start_nxt = (req_op[w_pick_owner] == OP_MUL);
          w_div_start_nxt = (req_op[w_pick_owner] == OP_DIV);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_ISSUE: begin
        // The start pulse is visible during ISSUE; done is not sampled here.
        w_state_nxt = S_WAIT;
`ifdef ARITH_SCHED_TIMEOUT_EN
        w_wd_cnt_nxt = '0;
`endif
      end

      S_WAIT: begin
        if (w_sel_done) begin
          w_state_nxt      = S_RESP;
          w_resp_data_nxt  = w_sel_result;
          w_resp_ovf_nxt   = w_sel_ovf;
          w_resp_valid_nxt = r_gnt;
        end
`ifdef ARITH_SCHED_TIMEOUT_EN
        else if (w_wd_expire) begin
          w_state_nxt      = S_RESP;
          w_resp_data_nxt  = '0;
          w_resp_ovf_nxt   = 1'b1;
          w_resp_valid_nxt = r_gnt;
          w_timeout_nxt    = 1'b1;
        end else begin
          w_wd_cnt_nxt = r_wd_cnt + WD_W'(1);
        end
`else
        else begin
          w_state_nxt = S_WAIT;
        end
`endif
      end

      S_RESP: begin
        // Last owner drops to lowest priority for the next pick.
        w_state_nxt  = S_IDLE;
        w_rr_ptr_nxt = w_owner_inc;
        w_gnt_nxt    = '0;
        w_busy_nxt   = 1'b0;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_owner      <= '0;
      r_op         <= OP_MUL;
      r_unit_a     <= '0;
      r_unit_b     <= '0;
      r_gnt        <= '0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_resp_ovf   <= 1'b0;
      r_busy       <= 1'b0;
      r_mul_start  <= 1'b0;
      r_div_start  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_owner      <= w_owner_nxt;
      r_op         <= w_op_nxt;
      r_unit_a     <= w_unit_a_nxt;
      r_unit_b     <= w_unit_b_nxt;
      r_gnt        <= w_gnt_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_data  <= w_resp_data_nxt;
      r_resp_ovf   <= w_resp_ovf_nxt;
      r_busy       <= w_busy_nxt;
      r_mul_start  <= w_mul_start_nxt;
      r_div_start  <= w_div_start_nxt;
    end
  end

`ifdef ARITH_SCHED_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wd_cnt  <= w_wd_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  assign gnt        = r_gnt;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_ovf   = r_resp_ovf;
  assign busy       = r_busy;
  assign unit_a     = r_unit_a;
  assign unit_b     = r_unit_b;
  assign mul_start  = r_mul_start;
  assign div_start  = r_div_start;

endmodule

// File: tb/tb_arith_unit_scheduler.sv
// -----------------------------------------------------------------------------
// tb_arith_unit_scheduler
//   Directed bench for arith_unit_scheduler (NUM_REQ=2, WORD_SIZE=16). A small
//   unit emulator answers start pulses with Q8.8 multiply/divide results after
//   a programmable latency. Expected responses are queued when requests are
//   raised; a monitor pops and compares on every resp_valid.
// -----------------------------------------------------------------------------
module tb_arith_unit_scheduler;

  localparam int NR = 2;
  localparam int WS = 16;
  localparam int TO = 8;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR-1:0]     req_op;
  logic [NR*WS-1:0]  req_a;
  logic [NR*WS-1:0]  req_b;
  logic [NR-1:0]     gnt;
  logic [NR-1:0]     resp_valid;
  logic [WS-1:0]     resp_data;
  logic              resp_ovf;
  logic              busy;
  logic              timeout;
  logic [WS-1:0]     unit_a;
  logic [WS-1:0]     unit_b;
  logic              mul_start;
  logic              div_start;
  logic [WS-1:0]     mul_result;
  logic              mul_done;
  logic              mul_ovf;
  logic [WS-1:0]     div_result;
  logic              div_done;
  logic              div_ovf;

  arith_unit_scheduler #(
    .NUM_REQ        (NR),
    .WORD_SIZE      (WS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .gnt        (gnt),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_ovf   (resp_ovf),
    .busy       (busy),
    .timeout    (timeout),
    .unit_a     (unit_a),
    .unit_b     (unit_b),
    .mul_start  (mul_start),
    .div_start  (div_start),
    .mul_result (mul_result),
    .mul_done   (mul_done),
    .mul_ovf    (mul_ovf),
    .div_result (div_result),
    .div_done   (div_done),
    .div_ovf    (div_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errs   = 0;

  typedef struct {
    int          owner;
    logic [15:0] data;
    logic        ovf;
    int          lat_mode;   // 0 none, 1 done+1, 2 exact cycle
    int          exp_cyc;
  } exp_t;

  exp_t sb[$];

  // Unit emulator controls
  int last_done_cyc = -100;
  int lat      = 6;
  bit suppress = 1'b0;
  bit spurious = 1'b0;
  bit early    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int owner, input logic [15:0] d, input logic o,
                          input int mode, input int ec);
    exp_t e;
    e.owner = owner; e.data = d; e.ovf = o; e.lat_mode = mode; e.exp_cyc = ec;
    sb.push_back(e);
  endtask

  task automatic set_op(input int i, input logic op, input logic [15:0] a, input logic [15:0] b);
    req_op[1'(i)]     = op;
    req_a[i*WS +: WS] = a;
    req_b[i*WS +: WS] = b;
  endtask

  task automatic wait_resp(input int idx, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (resp_valid[1'(idx)]) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_errs++;
      $display("FAIL wait_resp%0d: resp_valid not seen in %0d cycles, required within budget", idx, budget);
    end
  endtask

  task automatic wait_start(output int s);
    bit seen;
    seen = 1'b0;
    s = -1;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (mul_start || div_start) begin
        seen = 1'b1;
        s = cyc;
      end
    end
    n_checks++;
    if (!seen) begin
      n_errs++;
      $display("FAIL wait_start: no start pulse in 20 cycles, required one");
    end
  endtask

  task automatic wait_gnt(input logic [NR-1:0] g);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (gnt == g) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_errs++;
      $display("FAIL wait_gnt: gnt=%b never reached required %b", gnt, g);
    end
  endtask

  // Q8.8 unsigned multiply; overflow when the integer part exceeds 8 bits.
  function automatic logic [16:0] emu_mul(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = {16'h0000, a} * {16'h0000, b};
    return {|p[31:24], p[23:8]};
  endfunction

  // Q8.8 unsigned divide; divide-by-zero saturates with overflow.
  function automatic logic [16:0] emu_div(input logic [15:0] a, input logic [15:0] b);
    logic [23:0] q;
    if (b == 16'h0000) return {1'b1, 16'hFFFF};
    q = {a, 8'h00} / {8'h00, b};
    return {|q[23:16], q[15:0]};
  endfunction

  // Unit emulator: answers a start pulse with done after 'lat' cycles.
  initial begin
    bit          is_div;
    logic [16:0] rr;
    mul_done = 1'b0; div_done = 1'b0; mul_ovf = 1'b0; div_ovf = 1'b0;
    mul_result = 16'h0000; div_result = 16'h0000;
    forever begin
      @(negedge clk);
      if (!rst && (mul_start || div_start)) begin
        is_div = div_start;
        if (early) begin
          mul_result = 16'hBAD0; div_result = 16'hBAD0;
          if (is_div) div_done = 1'b1; else mul_done = 1'b1;
        end
        for (int k = 1; k <= lat; k++) begin
          @(posedge clk); #1;
          mul_done = 1'b0; div_done = 1'b0; mul_ovf = 1'b0; div_ovf = 1'b0;
          if (rst) break;
          if (spurious && k == 2) begin
            mul_done = 1'b1; mul_result = 16'hDEAD; mul_ovf = 1'b1;
          end
          if (k == lat && !suppress) begin
            if (is_div) begin
              rr = emu_div(unit_a, unit_b);
              div_result = rr[15:0]; div_ovf = rr[16]; div_done = 1'b1;
            end else begin
              rr = emu_mul(unit_a, unit_b);
              mul_result = rr[15:0]; mul_ovf = rr[16]; mul_done = 1'b1;
            end
            last_done_cyc = cyc;
          end
        end
        @(posedge clk); #1;
        mul_done = 1'b0; div_done = 1'b0; mul_ovf = 1'b0; div_ovf = 1'b0;
      end
    end
  end

  // Monitor: every resp_valid pops one expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && resp_valid !== 2'b00) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errs++;
          $display("FAIL unexpected_resp: resp_valid=%b data=%h, required no response", resp_valid, resp_data);
        end else begin
          e = sb.pop_front();
          chk("resp_valid", 32'(resp_valid), 32'(1) << e.owner);
          chk("resp_data",  32'(resp_data),  32'(e.data));
          chk("resp_ovf",   32'(resp_ovf),   32'(e.ovf));
          chk("resp_gnt",   32'(gnt),        32'(1) << e.owner);
          if (e.lat_mode == 1) chk("resp_latency", 32'(cyc), 32'(last_done_cyc + 1));
          else if (e.lat_mode == 2) chk("resp_cycle", 32'(cyc), 32'(e.exp_cyc));
        end
      end
    end
  end

  // Global time bound.
  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "time bound exceeded");
  end

  initial begin
    int s;
    rst = 1'b1; req = 2'b00; req_op = 2'b00; req_a = 32'h0; req_b = 32'h0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_gnt",   32'(gnt), 32'h0);
    chk("rst_resp",  32'({resp_valid, resp_ovf, resp_data}), 32'h0);
    chk("rst_busy",  32'({busy, timeout}), 32'h0);
    chk("rst_unit",  {unit_a, unit_b}, 32'h0);
    chk("rst_start", 32'({mul_start, div_start}), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single multiply, start latency and pulse width
    lat = 6;
    set_op(0, 1'b0, 16'h0180, 16'h0100);
    req[0] = 1'b1;
    push_exp(0, 16'h0180, 1'b0, 1, 0);
    @(negedge clk);
    chk("t1_start", 32'({mul_start, div_start}), 32'h2);
    chk("t1_gnt",   32'(gnt), 32'h1);
    chk("t1_busy",  32'(busy), 32'h1);
    chk("t1_unit",  {unit_a, unit_b}, 32'h0180_0100);
    @(negedge clk);
    chk("t1_start_pulse", 32'(mul_start), 32'h0);
    chk("t1_gnt_wait",    32'(gnt), 32'h1);
    wait_resp(0, 20);
    req[0] = 1'b0;
    @(negedge clk);
    chk("t1_idle", 32'({busy, gnt, resp_valid}), 32'h0);

    // 2: simultaneous requests from reset, re-request, rotation
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    lat = 3;
    set_op(0, 1'b0, 16'h0200, 16'h0300);
    set_op(1, 1'b0, 16'h0100, 16'h0080);
    req = 2'b11;
    push_exp(0, 16'h0600, 1'b0, 1, 0);
    push_exp(1, 16'h0080, 1'b0, 1, 0);
    wait_resp(0, 20);
    req[0] = 1'b0;
    wait_gnt(2'b10);
    set_op(0, 1'b0, 16'h0040, 16'h0400);
    req[0] = 1'b1;
    push_exp(0, 16'h0100, 1'b0, 1, 0);
    wait_resp(1, 20);
    req[1] = 1'b0;
    wait_gnt(2'b01);
    set_op(1, 1'b0, 16'h0280, 16'h0200);
    req[1] = 1'b1;
    push_exp(1, 16'h0500, 1'b0, 1, 0);
    wait_resp(0, 20);
    // requester 0 immediately asks again; requester 1 must win this round
    set_op(0, 1'b0, 16'h0100, 16'h0100);
    push_exp(0, 16'h0100, 1'b0, 1, 0);
    @(negedge clk);
    chk("t2_idle_gap", 32'(busy), 32'h0);
    wait_resp(1, 20);
    req[1] = 1'b0;
    wait_resp(0, 20);
    req[0] = 1'b0;

    // 3: divider overflow with a spurious multiplier done in WAIT
    lat = 5; spurious = 1'b1;
    set_op(1, 1'b1, 16'h0100, 16'h0000);
    req[1] = 1'b1;
    push_exp(1, 16'hFFFF, 1'b1, 1, 0);
    wait_resp(1, 20);
    req[1] = 1'b0; spurious = 1'b0;
    set_op(0, 1'b1, 16'h0300, 16'h0200);
    req[0] = 1'b1;
    push_exp(0, 16'h0180, 1'b0, 1, 0);
    wait_start(s);
    chk("t3_div_start", 32'({mul_start, div_start}), 32'h1);
    wait_resp(0, 20);
    req[0] = 1'b0;

    // 4: reset in WAIT abandons the operation and clears the round-robin pointer
    lat = 20;
    set_op(1, 1'b0, 16'h0100, 16'h0100);
    req[1] = 1'b1;
    wait_start(s);
    repeat (3) @(negedge clk);
    rst = 1'b1; req[1] = 1'b0;
    @(negedge clk);
    chk("t4_rst_gnt",  32'({gnt, resp_valid}), 32'h0);
    chk("t4_rst_out",  32'({resp_ovf, busy, timeout, mul_start, div_start}), 32'h0);
    chk("t4_rst_data", 32'(resp_data), 32'h0);
    chk("t4_rst_unit", {unit_a, unit_b}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    lat = 3;
    set_op(0, 1'b0, 16'h0080, 16'h0200);
    set_op(1, 1'b0, 16'h0300, 16'h0300);
    req = 2'b11;
    push_exp(0, 16'h0100, 1'b0, 1, 0);
    push_exp(1, 16'h0900, 1'b0, 1, 0);
    wait_resp(0, 20);
    req[0] = 1'b0;
    wait_resp(1, 20);
    req[1] = 1'b0;

    // 6: operands/op changed after latch, done in ISSUE ignored, req dropped
    lat = 4; early = 1'b1;
    set_op(0, 1'b0, 16'h0300, 16'h0200);
    req[0] = 1'b1;
    push_exp(0, 16'h0600, 1'b0, 1, 0);
    wait_start(s);
    set_op(0, 1'b1, 16'h1111, 16'h2222);
    @(negedge clk);
    early = 1'b0;
    chk("t6_unit_hold", {unit_a, unit_b}, 32'h0300_0200);
    req[0] = 1'b0;
    wait_resp(0, 20);
    @(negedge clk);
    chk("t6_unit_after", {unit_a, unit_b}, 32'h0300_0200);
    chk("t6_data_held",  32'(resp_data), 32'h0600);

`ifdef ARITH_SCHED_TIMEOUT_EN
    // 5: watchdog closes a WAIT that never sees done
    lat = 3; suppress = 1'b1;
    set_op(0, 1'b0, 16'h0100, 16'h0100);
    req[0] = 1'b1;
    wait_start(s);
    push_exp(0, 16'h0000, 1'b1, 2, s + 1 + TO);
    wait_resp(0, 30);
    req[0] = 1'b0; suppress = 1'b0;
    @(negedge clk);
    chk("t5_timeout_set", 32'(timeout), 32'h1);
    set_op(1, 1'b0, 16'h0100, 16'h0200);
    req[1] = 1'b1;
    push_exp(1, 16'h0200, 1'b0, 1, 0);
    wait_resp(1, 20);
    req[1] = 1'b0;
    @(negedge clk);
    chk("t5_timeout_sticky", 32'(timeout), 32'h1);
`else
    chk("timeout_tied", 32'(timeout), 32'h0);
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
